// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry
// registered between stages, valid/ready on both sides with a global stall.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  localparam int STAGES = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 2 and an exact multiple of CHUNK");
  end

  logic adv;

  // Index k of these holds what stage k consumes: raw inputs for k=0,
  // stage k-1 registers otherwise.
  logic [WIDTH-1:0]  a_s   [STAGES];
  logic [WIDTH-1:0]  bx_s  [STAGES];
  logic [WIDTH-1:0]  sum_s [STAGES];
  logic [STAGES-1:0] carry_s;
  logic [STAGES-1:0] valid_s;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign a_s[0]     = a;
  assign bx_s[0]    = b ^ {WIDTH{sub}};
  assign sum_s[0]   = '0;
  assign carry_s[0] = sub | cin;
  assign valid_s[0] = in_valid;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] sum_next;
    logic             valid_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] sum_reg;

    assign slice = {1'b0, a_s[gi][gi*CHUNK +: CHUNK]}
                 + {1'b0, bx_s[gi][gi*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry_s[gi]};

    always_comb begin
      sum_next = sum_s[gi];
      sum_next[gi*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    end

    // Data only loads for real transactions, so bubbles never disturb results.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (adv) begin
        valid_reg <= valid_s[gi];
        if (valid_s[gi]) begin
          carry_reg <= slice[CHUNK];
          sum_reg   <= sum_next;
        end
      end
    end

    if (gi < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] bx_reg;

      always_ff @(posedge clk) begin
        if (adv && valid_s[gi]) begin
          a_reg  <= a_s[gi];
          bx_reg <= bx_s[gi];
        end
      end

      assign a_s[gi+1]     = a_reg;
      assign bx_s[gi+1]    = bx_reg;
      assign sum_s[gi+1]   = sum_reg;
      assign carry_s[gi+1] = carry_reg;
      assign valid_s[gi+1] = valid_reg;
    end else begin : g_out
      logic ovf_reg;
      logic msb_cin;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      assign msb_cin = a_s[gi][WIDTH-1] ^ bx_s[gi][WIDTH-1] ^ slice[CHUNK-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_reg <= 1'b0;
        end else if (adv && valid_s[gi]) begin
          ovf_reg <= msb_cin ^ slice[CHUNK];
        end
      end

      assign out_valid = valid_reg;
      assign sum       = sum_reg;
      assign cout      = carry_reg;
      assign ovf       = ovf_reg;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases plus random backpressured streams on
// four parameterisations, checked in order against a queue-based scoreboard.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid_v  [4];
  logic        sub_v       [4];
  logic        cin_v       [4];
  logic        out_ready_v [4];
  logic [31:0] a_v         [4];
  logic [31:0] b_v         [4];
  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic        cout_w      [4];
  logic        ovf_w       [4];
  logic [31:0] sum_w       [4];
  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [31:0] sum2;
  logic [11:0] sum3;

  assign sum_w[0] = {16'h0, sum0};
  assign sum_w[1] = {24'h0, sum1};
  assign sum_w[2] = sum2;
  assign sum_w[3] = {20'h0, sum3};

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]), .sum(sum0),
    .cout(cout_w[0]), .ovf(ovf_w[0]));

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]), .sum(sum1),
    .cout(cout_w[1]), .ovf(ovf_w[1]));

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]), .sum(sum2),
    .cout(cout_w[2]), .ovf(ovf_w[2]));

  pipelined_adder #(.WIDTH(12), .CHUNK(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid_v[3]), .in_ready(in_ready_w[3]),
    .a(a_v[3][11:0]), .b(b_v[3][11:0]), .cin(cin_v[3]), .sub(sub_v[3]),
    .out_valid(out_valid_w[3]), .out_ready(out_ready_v[3]), .sum(sum3),
    .cout(cout_w[3]), .ovf(ovf_w[3]));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    bit          strict;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  bit          strict_mode = 1'b0;
  bit          dir_mode = 1'b0;
  logic [31:0] dir_sum;
  logic        dir_cout;
  logic        dir_ovf;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_sum;
  logic        prev_cout;
  logic        prev_ovf;

  function automatic int w_of(input int i);
    case (i)
      0: return 16;
      1: return 8;
      2: return 32;
      default: return 12;
    endcase
  endfunction

  function automatic int s_of(input int i);
    case (i)
      0: return 4;
      1: return 1;
      2: return 4;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  // Reference: {ovf, cout, sum} from full-precision arithmetic.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic sub);
    longint unsigned mask, aa, bb, full, s;
    logic co, ov, sa, sbb, ss;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'h0, a} & mask;
    bb   = (sub ? {32'h0, ~b} : {32'h0, b}) & mask;
    full = aa + bb + (sub ? 64'd1 : {63'h0, cin});
    s    = full & mask;
    co   = ((full >> w) & 64'd1) != 0;
    sa   = ((aa >> (w - 1)) & 64'd1) != 0;
    sbb  = ((bb >> (w - 1)) & 64'd1) != 0;
    ss   = ((s  >> (w - 1)) & 64'd1) != 0;
    ov   = (sa == sbb) && (ss != sa);
    return {ov, co, s[31:0]};
  endfunction

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b1;
      a_v[k] = $urandom;
      b_v[k] = $urandom;
      sub_v[k] = 1'b0;
      cin_v[k] = 1'b0;
    end
  endtask

  // One clock of instance i: scoreboard push/pop plus handshake and stall checks.
  task automatic tick(input int i, output bit accepted);
    exp_t        e;
    logic [33:0] r;
    accepted = 1'b0;
    #1;
    tests_run++;
    if (in_ready_w[i] !== !(out_valid_w[i] && !out_ready_v[i])) begin
      tests_failed++;
      $display("FAIL in_ready inst%0d cyc%0d: got %b, want %b", i, cyc, in_ready_w[i],
               !(out_valid_w[i] && !out_ready_v[i]));
    end
    if (prev_stall) begin
      tests_run++;
      if (out_valid_w[i] !== 1'b1 || sum_w[i] !== prev_sum || cout_w[i] !== prev_cout ||
          ovf_w[i] !== prev_ovf) begin
        tests_failed++;
        $display("FAIL stall_hold inst%0d cyc%0d: got v=%b sum=%h c=%b o=%b, want v=1 sum=%h c=%b o=%b",
                 i, cyc, out_valid_w[i], sum_w[i], cout_w[i], ovf_w[i], prev_sum, prev_cout, prev_ovf);
      end
    end
    if (out_valid_w[i] && out_ready_v[i]) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL spurious_output inst%0d cyc%0d: got sum=%h, want no output", i, cyc, sum_w[i]);
      end else begin
        e = sb.pop_front();
        if (sum_w[i] !== e.sum || cout_w[i] !== e.cout || ovf_w[i] !== e.ovf) begin
          tests_failed++;
          $display("FAIL result inst%0d cyc%0d: got sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
                   i, cyc, sum_w[i], cout_w[i], ovf_w[i], e.sum, e.cout, e.ovf);
        end
        if (e.strict) begin
          tests_run++;
          if (cyc - e.cyc != s_of(i)) begin
            tests_failed++;
            $display("FAIL latency inst%0d: got %0d, want %0d", i, cyc - e.cyc, s_of(i));
          end
        end
      end
    end
    if (in_valid_v[i] && in_ready_w[i]) begin
      if (dir_mode) begin
        e.sum = dir_sum; e.cout = dir_cout; e.ovf = dir_ovf;
      end else begin
        r = ref_add(w_of(i), a_v[i], b_v[i], cin_v[i], sub_v[i]);
        e.sum = r[31:0]; e.cout = r[32]; e.ovf = r[33];
      end
      e.cyc = cyc;
      e.strict = strict_mode;
      sb.push_back(e);
      accepted = 1'b1;
    end
    prev_stall = out_valid_w[i] && !out_ready_v[i];
    prev_sum   = sum_w[i];
    prev_cout  = cout_w[i];
    prev_ovf   = ovf_w[i];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_txn(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
    bit acc;
    int n;
    in_valid_v[i] = 1'b1;
    a_v[i] = a; b_v[i] = b; cin_v[i] = cin; sub_v[i] = sub;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      tick(i, acc);
      n++;
    end
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout inst%0d: got no accept in %0d cycles, want accept", i, n);
    end
    in_valid_v[i] = 1'b0;
  endtask

  task automatic send_dir(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic [31:0] es, input logic ec,
                          input logic eo);
    dir_mode = 1'b1;
    dir_sum = es; dir_cout = ec; dir_ovf = eo;
    send_txn(0, a, b, cin, sub);
    dir_mode = 1'b0;
  endtask

  task automatic drain(input int i);
    bit acc;
    in_valid_v[i]  = 1'b0;
    out_ready_v[i] = 1'b1;
    for (int k = 0; k < 60 && sb.size() > 0; k++) tick(i, acc);
    for (int k = 0; k < s_of(i) + 2; k++) tick(i, acc);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain inst%0d: got %0d results missing, want 0", i, sb.size());
      sb.delete();
    end
    prev_stall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (out_valid_w[k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_out_valid inst%0d: got %b, want 0", k, out_valid_w[k]);
      end
    end
    tests_run++;
    if (sum_w[0] !== 32'h0 || cout_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got sum=%h c=%b o=%b, want 0 0 0", sum_w[0], cout_w[0], ovf_w[0]);
    end
    reset = 1'b0;
    out_ready_v[0] = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready_w[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready_w[0]);
    end
    out_ready_v[0] = 1'b1;
    $display("[TB] reset: outputs cleared, in_ready after release = %b", in_ready_w[0]);
  endtask

  task automatic test_single_add();
    strict_mode = 1'b1;
    send_dir(32'h1234, 32'h0FCD, 1'b0, 1'b0, 32'h2201, 1'b0, 1'b0);
    drain(0);
    $display("[TB] single add 0x1234+0x0FCD done");
  endtask

  task automatic test_carry_ripple();
    strict_mode = 1'b1;
    send_dir(32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0);
    send_dir(32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
    drain(0);
    $display("[TB] carry ripple 0xFFFF+1 and 0x7FFF+1 done");
  endtask

  task automatic test_subtract();
    strict_mode = 1'b1;
    send_dir(32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0);
    send_dir(32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1);
    drain(0);
    $display("[TB] subtract 5-7 and 0x8000-1 done");
  endtask

  // Phase 1: full throughput with out_ready=1; phase 2: random backpressure.
  task automatic test_back_to_back(input int i, input int n);
    bit acc;
    int sent;
    int budget;
    logic [31:0] m;
    m = mask_of(w_of(i));
    strict_mode = 1'b1;
    out_ready_v[i] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid_v[i] = 1'b1;
      a_v[i] = $urandom & m; b_v[i] = $urandom & m;
      sub_v[i] = 1'($urandom_range(0, 1)); cin_v[i] = 1'($urandom_range(0, 1));
      tick(i, acc);
      tests_run++;
      if (!acc) begin
        tests_failed++;
        $display("FAIL full_throughput inst%0d: got no accept on beat %0d, want accept", i, k);
      end
    end
    drain(i);
    strict_mode = 1'b0;
    sent = 0;
    budget = 0;
    a_v[i] = $urandom & m; b_v[i] = $urandom & m;
    sub_v[i] = 1'($urandom_range(0, 1)); cin_v[i] = 1'($urandom_range(0, 1));
    while (sent < n && budget < 500) begin
      in_valid_v[i]  = 1'b1;
      out_ready_v[i] = 1'($urandom_range(0, 1));
      tick(i, acc);
      if (acc) begin
        sent++;
        a_v[i] = $urandom & m; b_v[i] = $urandom & m;
        sub_v[i] = 1'($urandom_range(0, 1)); cin_v[i] = 1'($urandom_range(0, 1));
      end
      budget++;
    end
    tests_run++;
    if (sent != n) begin
      tests_failed++;
      $display("FAIL stream_send inst%0d: got %0d sent, want %0d", i, sent, n);
    end
    drain(i);
    $display("[TB] stream inst%0d width=%0d stages=%0d: %0d transactions", i, w_of(i), s_of(i), sent);
  endtask

  task automatic test_reset_midflight();
    strict_mode = 1'b1;
    for (int k = 0; k < 3; k++) send_txn(0, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 1'b0, 1'(k));
    reset = 1'b1;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    in_valid_v[0] = 1'b0;
    tests_run++;
    if (out_valid_w[0] !== 1'b0 || sum_w[0] !== 32'h0) begin
      tests_failed++;
      $display("FAIL midflight_reset: got v=%b sum=%h, want v=0 sum=0", out_valid_w[0], sum_w[0]);
    end
    sb.delete();
    prev_stall = 1'b0;
    drain(0);
    send_dir(32'h0100, 32'h0023, 1'b1, 1'b0, 32'h0124, 1'b0, 1'b0);
    drain(0);
    $display("[TB] reset mid-flight: in-flight work discarded, new add checked");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_add();
    test_carry_ripple();
    test_subtract();
    test_back_to_back(0, 20);
    test_reset_midflight();
    test_back_to_back(1, 20);
    test_back_to_back(2, 20);
    test_back_to_back(3, 20);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
